// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared request/response types and FSM states for reg_bus_adapter
package reg_bus_pkg;
  localparam int RB_AW = 8;
  localparam int RB_DW = 32;
  localparam int RB_NUM_REGS = 16;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} reg_bus_state_e;
  typedef struct packed {
    logic [RB_AW-1:0]   addr;
    logic               write;
    logic [RB_DW-1:0]   wdata;
    logic [RB_DW/8-1:0] be;
  } reg_bus_req_t;
  typedef struct packed {
    logic [RB_DW-1:0] rdata;
    logic             err;
  } reg_bus_rsp_t;
endpackage

// File: rtl/reg_bus_adapter.sv
// reg_bus_adapter: valid/ready bus to prim_reg SW port bridge, one strobe per accepted request
import reg_bus_pkg::*;
module reg_bus_adapter #(
  parameter int AW = RB_AW,
  parameter int DW = RB_DW,
  parameter int NUM_REGS = RB_NUM_REGS,
  localparam int IW = $clog2(NUM_REGS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [AW-1:0] req_addr_i,
  input  logic          req_write_i,
  input  logic [DW-1:0] req_wdata_i,
  input  logic [DW/8-1:0] req_be_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          rsp_err_o,
  output logic          reg_we_o,
  output logic          reg_re_o,
  output logic [IW-1:0] reg_idx_o,
  output logic [DW-1:0] reg_wdata_o,
  input  logic [DW-1:0] reg_rdata_i,
  input  logic          reg_error_i
);
  localparam int OB = $clog2(DW/8);
  localparam logic [AW-OB:0] NR = (AW-OB+1)'(NUM_REGS);
  reg_bus_state_e state_q, state_d;
  reg_bus_req_t req_q, req_d;
  reg_bus_rsp_t rsp_q, rsp_d;
  logic accept, dec_err, acc_err;
  // Decode error is a pure function of the latched request, so it is evaluated from req_q
  always_comb begin
    accept = req_valid_i & req_ready_o;
    dec_err = (|req_q.addr[OB-1:0]) | ({1'b0, req_q.addr[AW-1:OB]} >= NR) | (req_q.write & ~&req_q.be);
    acc_err = dec_err | reg_error_i;
    state_d = accept ? ACCESS : (state_q == ACCESS) ? RESP : (state_q == RESP && rsp_ready_i) ? IDLE : state_q;
    req_d = accept ? reg_bus_req_t'{addr: req_addr_i, write: req_write_i, wdata: req_wdata_i, be: req_be_i} : req_q;
    rsp_d = (state_q == ACCESS) ? reg_bus_rsp_t'{rdata: (!req_q.write && !acc_err) ? reg_rdata_i : '0, err: acc_err} : rsp_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q <= '0;
      rsp_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      rsp_q <= rsp_d;
    end
  end
  assign req_ready_o = (state_q == IDLE) & ~rst_i;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_rdata_o = rsp_q.rdata;
  assign rsp_err_o = rsp_q.err;
  assign reg_we_o = (state_q == ACCESS) & req_q.write & ~dec_err;
  assign reg_re_o = (state_q == ACCESS) & ~req_q.write & ~dec_err;
  assign reg_idx_o = req_q.addr[OB+IW-1:OB];
  assign reg_wdata_o = req_q.wdata;
endmodule

// File: tb/tb_reg_bus_adapter.sv
// tb_reg_bus_adapter: directed self-checking bench with a small register-file model (reg 5 is RC, reg 15 is a hole)
module tb_reg_bus_adapter;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_write = 0, rsp_valid, rsp_ready = 0, rsp_err;
  logic [7:0] req_addr = 0;
  logic [31:0] req_wdata = 0, rsp_rdata, reg_wdata, reg_rdata;
  logic [3:0] req_be = 0, reg_idx;
  logic reg_we, reg_re, reg_error;
  int vec = 0, miss = 0, cyc = 0, we_cnt = 0, re_cnt = 0;
  logic [31:0] regs [16];
  int acc_cyc [$];
  logic [31:0] rsp_log [$];
  reg_bus_adapter dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_write_i(req_write), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .reg_we_o(reg_we), .reg_re_o(reg_re), .reg_idx_o(reg_idx), .reg_wdata_o(reg_wdata),
    .reg_rdata_i(reg_rdata), .reg_error_i(reg_error)
  );
  always #5 clk = ~clk;
  assign reg_rdata = regs[reg_idx];
  assign reg_error = reg_idx == 4'hF;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'h1000_0000 + i;
      regs[3] <= 32'h1234_5678;
      regs[5] <= 32'h1;
      regs[15] <= 32'hDEAD_BEEF;
    end else begin
      if (reg_we) begin
        regs[reg_idx] <= reg_wdata;
        we_cnt <= we_cnt + 1;
      end
      if (reg_re) begin
        re_cnt <= re_cnt + 1;
        if (reg_idx == 4'd5) regs[5] <= 32'h0;
      end
      if (req_valid && req_ready) acc_cyc.push_back(cyc);
      if (rsp_valid && rsp_ready) rsp_log.push_back(rsp_rdata);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] a, input logic w, input logic [31:0] d, input logic [3:0] b);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", req_ready, 1);
    req_valid = 1; req_addr = a; req_write = w; req_wdata = d; req_be = b;
    @(negedge clk);
    req_valid = 0;
  endtask
  task automatic txn(input string tag, input logic [7:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] b, input int stall, output logic [31:0] rd, output logic e,
                     output int dwe, output int dre);
    int w0 = we_cnt, r0 = re_cnt;
    logic [31:0] first;
    send(a, w, d, b);
    chk({tag, "_access_no_rsp"}, rsp_valid, 0);
    chk({tag, "_idx"}, reg_idx, a[5:2]);
    @(negedge clk);
    chk({tag, "_rsp_latency"}, rsp_valid, 1);
    first = rsp_rdata;
    repeat (stall) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, rsp_valid, 1);
      chk({tag, "_hold_rdata"}, rsp_rdata, first);
      chk({tag, "_ready_low"}, req_ready, 0);
    end
    rsp_ready = 1;
    rd = rsp_rdata;
    e = rsp_err;
    @(negedge clk);
    rsp_ready = 0;
    chk({tag, "_rsp_done"}, rsp_valid, 0);
    dwe = we_cnt - w0;
    dre = re_cnt - r0;
  endtask
  initial begin
    logic [31:0] rd;
    logic e;
    int dwe, dre, w0, n, base, seen;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_re", reg_re, 0);
    chk("rst_idx", reg_idx, 0);
    chk("rst_wdata", reg_wdata, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    txn("wr08", 8'h08, 1, 32'hA5A5_0F0F, 4'hF, 0, rd, e, dwe, dre);
    chk("wr08_err", e, 0); chk("wr08_rdata", rd, 0);
    chk("wr08_we_pulses", dwe, 1); chk("wr08_re_pulses", dre, 0);
    chk("wr08_reg2", regs[2], 32'hA5A5_0F0F);
    txn("rd0c", 8'h0C, 0, 0, 4'h0, 5, rd, e, dwe, dre);
    chk("rd0c_rdata", rd, 32'h1234_5678); chk("rd0c_err", e, 0);
    chk("rd0c_re_pulses", dre, 1); chk("rd0c_we_pulses", dwe, 0);
    txn("rd05", 8'h05, 0, 0, 4'h0, 0, rd, e, dwe, dre);
    chk("rd05_err", e, 1); chk("rd05_rdata", rd, 0); chk("rd05_strobes", dwe + dre, 0);
    txn("rd40", 8'h40, 0, 0, 4'h0, 0, rd, e, dwe, dre);
    chk("rd40_err", e, 1); chk("rd40_rdata", rd, 0); chk("rd40_strobes", dwe + dre, 0);
    txn("wr04", 8'h04, 1, 32'h5555_AAAA, 4'h3, 0, rd, e, dwe, dre);
    chk("wr04_err", e, 1); chk("wr04_rdata", rd, 0); chk("wr04_strobes", dwe + dre, 0);
    chk("wr04_reg1", regs[1], 32'h1000_0001);
    txn("rd3c", 8'h3C, 0, 0, 4'h0, 0, rd, e, dwe, dre);
    chk("rd3c_err", e, 1); chk("rd3c_rdata", rd, 0); chk("rd3c_re_pulses", dre, 1);
    txn("rc1", 8'h14, 0, 0, 4'h0, 3, rd, e, dwe, dre);
    chk("rc1_rdata", rd, 32'h1); chk("rc1_re_pulses", dre, 1); chk("rc1_cleared", regs[5], 0);
    txn("rc2", 8'h14, 0, 0, 4'h0, 0, rd, e, dwe, dre);
    chk("rc2_rdata", rd, 32'h0); chk("rc2_err", e, 0);
    w0 = we_cnt;
    send(8'h18, 1, 32'hCAFE_BABE, 4'hF);
    chk("rst_mid_we_before", reg_we, 1);
    rst = 1;
    #1 chk("rst_mid_we_dropped", reg_we, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_rsp_valid", rsp_valid, 0);
      chk("rst_mid_ready", req_ready, 0);
    end
    rst = 0;
    @(negedge clk);
    chk("rst_mid_ready_after", req_ready, 1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rst_mid_no_rsp", seen, 0);
    chk("rst_mid_we_pulses", we_cnt - w0, 0);
    chk("rst_mid_reg6", regs[6], 32'h1000_0006);
    rsp_ready = 1;
    base = acc_cyc.size();
    rsp_log.delete();
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_ready", req_ready, 1);
      req_valid = 1; req_write = 0; req_addr = 8'h20 + 8'(4 * k);
      @(negedge clk);
    end
    req_valid = 0;
    repeat (4) @(negedge clk);
    rsp_ready = 0;
    chk("b2b_accepts", acc_cyc.size() - base, 4);
    for (int k = 0; k < 3; k++)
      chk("b2b_gap", (acc_cyc.size() > base + k + 1) ? acc_cyc[base+k+1] - acc_cyc[base+k] : 0, 3);
    chk("b2b_rsps", rsp_log.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("b2b_rdata", (rsp_log.size() > k) ? rsp_log[k] : 32'hX, 32'h1000_0008 + k);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
